axis_packet_fifo: RTL and testbench
===================================

# axis_packet_fifo

Synthesizable store-and-forward AXI-Stream packet buffer: the RTL device that sits between `axis_source` (upstream) and `axis_sink` (downstream) in our benches, and between stream producers and consumers in the design. Accepts beats on the slave port, holds them until the packet's `last` beat arrives, then replays the complete packet on the master port with data, keep and last unchanged. Packets longer than the buffer are dropped whole and flagged; downstream never sees a partial packet.

## Interface
- `WORD_W`, 8, bits per word
- `BUS_W`, 32, bus width in bits; `WORDS_PER_BEAT = BUS_W/WORD_W`
- `DEPTH`, 64, buffer capacity in beats; power of two, ≥ 4
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `s_valid`  in  1  slave beat valid
- `s_ready`  out  1  slave beat ready
- `s_data`  in  WORDS_PER_BEAT×WORD_W  slave data, packed `[WORDS_PER_BEAT-1:0][WORD_W-1:0]`
- `s_keep`  in  WORDS_PER_BEAT  slave byte/word enables
- `s_last`  in  1  final beat of packet
- `m_valid`, `m_ready`, `m_data`, `m_keep`, `m_last`  out/in/out/out/out  same widths, master side
- `pkt_count`  out  $clog2(DEPTH+1)  complete packets held (including one in output register)
- `fill`  out  $clog2(DEPTH+1)  beats held, committed plus in-progress
- `drop`  out  1  one-cycle pulse when an oversize packet finishes being discarded

## Operation
- Circular beat RAM of `DEPTH` entries storing {data, keep, last}. Pointers: `wr_ptr` (next write), `commit_ptr` (entry after last committed `last` beat), `rd_ptr` (next read). Pointers are `$clog2(DEPTH)` bits and wrap naturally; full/empty decided by `fill`, never by pointer compare.
- Write FSM, states ACCEPT and DROP.
  - ACCEPT: `s_ready = (fill < DEPTH)`. On handshake write beat at `wr_ptr`, increment. If `s_last`, `commit_ptr <= wr_ptr+1`, `pkt_count` +1.
  - ACCEPT→DROP when `fill == DEPTH` and no committed packet exists (`commit_ptr == rd_ptr` with no beat in output register): `wr_ptr <= commit_ptr`, `fill` reduced by uncommitted beats.
  - DROP: `s_ready = 1`; beats discarded. Handshake with `s_last` → ACCEPT, `drop` pulses that cycle.
  - The beat that makes `fill == DEPTH` with `s_last = 1` commits normally; no drop.
- Read side: output register loaded from RAM when committed beats exist beyond `rd_ptr` and register is empty or handshaking. On handshake of a beat with `m_last`, `pkt_count` −1. Beats of uncommitted packets are never read.
- Simultaneous commit and final-beat read: `pkt_count` unchanged; `fill` +1 −1 unchanged.
- `keep` passed verbatim, including all-zero keep.

## Timing
- Reset: `s_ready=0`, `m_valid=0`, `m_data=0`, `m_keep=0`, `m_last=0`, `drop=0`, `pkt_count=0`, `fill=0`, FSM=ACCEPT, all pointers 0. `s_ready` rises the first edge after `rst` deasserts.
- Reset mid-packet: all content discarded; nothing emitted afterward.
- Latency: `last` beat accepted at edge N → first beat of that packet on master with `m_valid=1` after edge N+2 (one cycle commit, one cycle RAM read).
- Within a committed packet and across back-to-back committed packets, master sustains one beat per cycle while `m_ready=1`; no bubbles.
- `m_valid`/`m_data` held stable while `m_valid && !m_ready`.
- Slave: full throughput while `fill < DEPTH`. `s_ready` does not depend combinationally on `s_valid`; `m_valid` does not depend on `m_ready`.

## Structure
- Shared package `axis_pkg`: `WORD_W`, `BUS_W`, `WORDS_PER_BEAT` defaults, `axis_beat_t` struct {data, keep, last}, write-FSM enum `{ACCEPT, DROP}`.
- Sub-module `axis_beat_ram`: simple dual-port RAM, one write port, one registered read port, `DEPTH` × `axis_beat_t`.

## Test plan
- `DEPTH=16`, 20 random packets of 1–12 beats, `PROB_VALID=1`, `PROB_READY=10` via `axis_source`/`axis_sink` → received queues equal sent queues, `drop` never pulses.
- Single 1-beat packet, data 0xDEADBEEF, keep 4'b0111, `m_ready=1` → `m_valid` rises after edge N+2, beat matches, `pkt_count` 1→0.
- `DEPTH=16`, 20-beat packet then 3-beat packet → `drop` pulses once at beat 20, only the 3-beat packet emerges, `fill` returns to 0.
- `DEPTH=16`, exactly 16-beat packet with `m_ready=0` → `s_ready` low after beat 16, no drop; release `m_ready` → all 16 beats output, no bubbles.
- Pointer wrap: 40 consecutive 5-beat packets, `m_ready` always 1 → all packets intact, throughput 1 beat/cycle after initial latency.
- Assert `rst` for 2 cycles mid-packet (beat 3 of 8) → outputs return to reset values; next packet passes intact.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream defaults, beat record and write-side FSM states
// used by the packet FIFO and its beat RAM.
package axis_pkg;

  localparam int WORD_W         = 8;
  localparam int BUS_W          = 32;
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W;

  typedef struct packed {
    logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data;
    logic [WORDS_PER_BEAT-1:0]             keep;
    logic                                  last;
  } axis_beat_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_e;

endpackage

// File: rtl/axis_beat_ram.sv
// Simple dual-port beat store: one write port, one read port whose output
// register doubles as the FIFO's master-side holding register.
module axis_beat_ram
  import axis_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = $bits(axis_beat_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The read register holds its value when not enabled so a stalled beat stays stable.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet buffer: a packet is replayed only once
// its last beat is stored; packets larger than the buffer are discarded whole.
module axis_packet_fifo #(
  parameter int WORD_W = axis_pkg::WORD_W,
  parameter int BUS_W  = axis_pkg::BUS_W,
  parameter int DEPTH  = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [BUS_W/WORD_W-1:0][WORD_W-1:0]     s_data,
  input  logic [BUS_W/WORD_W-1:0]                 s_keep,
  input  logic                                    s_last,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [BUS_W/WORD_W-1:0][WORD_W-1:0]     m_data,
  output logic [BUS_W/WORD_W-1:0]                 m_keep,
  output logic                                    m_last,
  output logic [$clog2(DEPTH+1)-1:0]              pkt_count,
  output logic [$clog2(DEPTH+1)-1:0]              fill,
  output logic                                    drop
);

  import axis_pkg::*;

  localparam int WPB = BUS_W / WORD_W;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [WPB-1:0][WORD_W-1:0] data;
    logic [WPB-1:0]             keep;
    logic                       last;
  } beat_t;

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] cnext_q, cnext_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] pkt_q, pkt_d;
  logic [CW-1:0] avail_q, avail_d;
  logic [CW-1:0] cur_len_q, cur_len_d;
  logic [CW-1:0] cmt_len_q, cmt_len_d;
  logic          pend_q, pend_d;
  logic          out_valid_q, out_valid_d;
  logic          live_q;

  logic          wr_hs, rd_hs, load, no_committed, enter_drop;
  beat_t         wr_beat, rd_beat;

  assign wr_beat = {s_data, s_keep, s_last};

  axis_beat_ram #(
    .DEPTH (DEPTH),
    .W     ($bits(beat_t))
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_hs),
    .waddr (wr_ptr_q),
    .wdata (wr_beat),
    .re    (load),
    .raddr (rd_ptr_q),
    .rdata (rd_beat)
  );

  // A last beat commits one cycle after it is stored (pend_q), which keeps the
  // drop decision from seeing a just-finished packet as uncommitted.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnext_d      = cnext_q;
    cur_len_d    = cur_len_q;
    cmt_len_d    = cmt_len_q;
    pend_d       = 1'b0;
    s_ready      = 1'b0;
    drop         = 1'b0;
    wr_hs        = 1'b0;
    enter_drop   = 1'b0;
    no_committed = (pkt_q == '0) && !pend_q;

    case (state_q)
      ACCEPT: begin
        s_ready = live_q && (fill_q < DEPTH_C);
        wr_hs   = s_valid && s_ready;
        if (wr_hs) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (s_last) begin
            pend_d    = 1'b1;
            cnext_d   = wr_ptr_q + PW'(1);
            cmt_len_d = cur_len_q + CW'(1);
            cur_len_d = '0;
          end else begin
            cur_len_d = cur_len_q + CW'(1);
          end
        end else if ((fill_q == DEPTH_C) && no_committed) begin
          enter_drop = 1'b1;
          state_d    = DROP;
          wr_ptr_d   = commit_ptr_q;
          cur_len_d  = '0;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          drop    = 1'b1;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_comb begin
    rd_hs        = out_valid_q && m_ready;
    load         = (avail_q != '0) && (!out_valid_q || m_ready);
    rd_ptr_d     = load ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    out_valid_d  = load ? 1'b1 : (rd_hs ? 1'b0 : out_valid_q);
    avail_d      = avail_q - CW'(load) + (pend_q ? cmt_len_q : '0);
    commit_ptr_d = pend_q ? cnext_q : commit_ptr_q;
    pkt_d        = pkt_q + CW'(pend_q) - CW'(rd_hs && rd_beat.last);
    fill_d       = enter_drop ? (fill_q - cur_len_q)
                              : (fill_q + CW'(wr_hs) - CW'(rd_hs));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      cnext_q      <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      pkt_q        <= '0;
      avail_q      <= '0;
      cur_len_q    <= '0;
      cmt_len_q    <= '0;
      pend_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      cnext_q      <= cnext_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      pkt_q        <= pkt_d;
      avail_q      <= avail_d;
      cur_len_q    <= cur_len_d;
      cmt_len_q    <= cmt_len_d;
      pend_q       <= pend_d;
      out_valid_q  <= out_valid_d;
      live_q       <= 1'b1;
    end
  end

  assign m_valid   = out_valid_q;
  assign m_data    = rd_beat.data;
  assign m_keep    = rd_beat.keep;
  assign m_last    = rd_beat.last;
  assign pkt_count = pkt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed self-checking bench for axis_packet_fifo with a 16-beat buffer.
module tb_axis_packet_fifo;

  localparam int DEPTH      = 16;
  localparam int CW         = $clog2(DEPTH + 1);
  localparam int WAIT_LIMIT = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid, s_ready, s_last;
  logic [3:0][7:0] s_data, m_data;
  logic [3:0]      s_keep, m_keep;
  logic            m_valid, m_ready, m_last, drop;
  logic [CW-1:0]   pkt_count, fill;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dropCnt = 0;
  int sendTimeouts = 0;
  logic [36:0] expQ[$];
  logic [36:0] rxQ[$];
  int          rxCyc[$];
  logic        stallPrev = 1'b0;
  logic [36:0] stallBeat;

  axis_packet_fifo #(
    .WORD_W (8),
    .BUS_W  (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .pkt_count (pkt_count),
    .fill      (fill),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Output beats are sampled mid-cycle; a stalled beat must not change before it is taken.
  always @(negedge clk) begin
    if (!rst) begin
      if (stallPrev) begin
        checkOutput("stall_valid", m_valid, 1'b1);
        checkOutput("stall_beat", {m_data, m_keep, m_last}, stallBeat);
      end
      if (m_valid && m_ready) begin
        rxQ.push_back({m_data, m_keep, m_last});
        rxCyc.push_back(cyc);
      end
      if (drop) dropCnt++;
      stallPrev = m_valid && !m_ready;
      stallBeat = {m_data, m_keep, m_last};
    end else begin
      stallPrev = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [31:0] base, input int len, input bit record, input bit complete);
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          waitCnt;
    for (int i = 0; i < len; i++) begin
      d = base + 32'(i);
      k = d[3:0] ^ d[7:4];
      l = complete && (i == len - 1);
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      waitCnt = 0;
      @(negedge clk);
      while (!s_ready && waitCnt < WAIT_LIMIT) begin
        @(negedge clk);
        waitCnt++;
      end
      if (waitCnt >= WAIT_LIMIT) sendTimeouts++;
      @(posedge clk);
      #1;
      if (record) expQ.push_back({d, k, l});
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitRx(input int n);
    int c;
    c = 0;
    while (rxQ.size() < n && c < 500) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compareRx(input string tag);
    checkOutput({tag, "_count"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      checkOutput({tag, "_beat"}, rxQ[i], expQ[i]);
    end
  endtask

  task automatic clearScoreboard();
    expQ.delete();
    rxQ.delete();
    rxCyc.delete();
    dropCnt = 0;
    sendTimeouts = 0;
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", s_ready, 1'b0);
    checkOutput("rst_m_valid", m_valid, 1'b0);
    checkOutput("rst_m_data", m_data, 32'h0);
    checkOutput("rst_m_keep", m_keep, 4'h0);
    checkOutput("rst_m_last", m_last, 1'b0);
    checkOutput("rst_drop", drop, 1'b0);
    checkOutput("rst_pkt_count", pkt_count, 0);
    checkOutput("rst_fill", fill, 0);
    rst = 1'b0;
    #1;
    checkOutput("s_ready_before_edge", s_ready, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("s_ready_after_edge", s_ready, 1'b1);

    // Single-beat packet: commit after edge N+1, visible on master after N+2.
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'hDEADBEEF; s_keep = 4'b0111; s_last = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("single_fill_n", fill, 1);
    checkOutput("single_pkt_n", pkt_count, 0);
    checkOutput("single_valid_n", m_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("single_pkt_n1", pkt_count, 1);
    checkOutput("single_valid_n1", m_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("single_valid_n2", m_valid, 1'b1);
    checkOutput("single_data", m_data, 32'hDEADBEEF);
    checkOutput("single_keep", m_keep, 4'b0111);
    checkOutput("single_last", m_last, 1'b1);
    checkOutput("single_pkt_n2", pkt_count, 1);
    @(posedge clk);
    #1;
    checkOutput("single_valid_n3", m_valid, 1'b0);
    checkOutput("single_pkt_n3", pkt_count, 0);
    checkOutput("single_fill_n3", fill, 0);

    // Oversize 20-beat packet is dropped, the following 3-beat packet survives.
    clearScoreboard();
    applyStimulus(32'h100, 20, 1'b0, 1'b1);
    applyStimulus(32'h200, 3, 1'b1, 1'b1);
    waitRx(3);
    compareRx("drop_pkt");
    checkOutput("drop_pulses", dropCnt, 1);
    checkOutput("drop_fill", fill, 0);
    checkOutput("drop_pkt_count", pkt_count, 0);
    checkOutput("drop_timeouts", sendTimeouts, 0);

    // Exactly-full packet commits; nothing is released until m_ready rises.
    clearScoreboard();
    m_ready = 1'b0;
    applyStimulus(32'h300, 16, 1'b1, 1'b1);
    checkOutput("full_fill", fill, 16);
    checkOutput("full_s_ready", s_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full_s_ready_hold", s_ready, 1'b0);
    checkOutput("full_m_valid", m_valid, 1'b1);
    checkOutput("full_m_data", m_data, 32'h300);
    checkOutput("full_m_keep_zero", m_keep, 4'h0);
    checkOutput("full_pkt_count", pkt_count, 1);
    checkOutput("full_no_drop", dropCnt, 0);
    m_ready = 1'b1;
    waitRx(16);
    compareRx("full_pkt");
    if (rxCyc.size() == 16) checkOutput("full_no_bubble", rxCyc[15] - rxCyc[0], 15);
    checkOutput("full_fill_end", fill, 0);
    checkOutput("full_timeouts", sendTimeouts, 0);

    // Mixed lengths under intermittent backpressure.
    clearScoreboard();
    fork
      begin
        applyStimulus(32'h400, 1, 1'b1, 1'b1);
        applyStimulus(32'h410, 3, 1'b1, 1'b1);
        applyStimulus(32'h420, 7, 1'b1, 1'b1);
        applyStimulus(32'h430, 2, 1'b1, 1'b1);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk);
          #1;
          m_ready = (k % 3) != 0;
        end
        m_ready = 1'b1;
      end
    join
    waitRx(13);
    compareRx("bp_pkt");
    checkOutput("bp_pkt_count", pkt_count, 0);
    checkOutput("bp_no_drop", dropCnt, 0);

    // Forty 5-beat packets wrap the pointers repeatedly at full rate.
    clearScoreboard();
    m_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      applyStimulus(32'h1000 + 32'(p * 16), 5, 1'b1, 1'b1);
    end
    waitRx(200);
    compareRx("wrap_pkt");
    if (rxCyc.size() == 200) checkOutput("wrap_throughput", rxCyc[199] - rxCyc[0], 199);
    checkOutput("wrap_fill", fill, 0);
    checkOutput("wrap_no_drop", dropCnt, 0);
    checkOutput("wrap_timeouts", sendTimeouts, 0);

    // Reset in the middle of an 8-beat packet discards it.
    clearScoreboard();
    applyStimulus(32'h500, 3, 1'b0, 1'b0);
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    checkOutput("midrst_s_ready", s_ready, 1'b0);
    checkOutput("midrst_m_valid", m_valid, 1'b0);
    checkOutput("midrst_fill", fill, 0);
    checkOutput("midrst_pkt_count", pkt_count, 0);
    checkOutput("midrst_m_data", m_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midrst_nothing_out", rxQ.size(), 0);
    applyStimulus(32'h600, 4, 1'b1, 1'b1);
    waitRx(4);
    compareRx("post_rst_pkt");
    checkOutput("post_rst_fill", fill, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
